mult_arbiter: RTL and testbench

Round-robin arbiter that shares one multiplier (8-bit operands, 16-bit product, `en`/`ack` handshake) among `NUM_REQ` requesters. It latches the winner's operands, sequences the multiplier's enable/acknowledge handshake, and returns the product to the winning requester with a one-cycle done pulse. It sits between the requesters and the multiplier's RTL-side interface.

---
 rtl/mult_arbiter_if.sv | 31 +++
 rtl/mult_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mult_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: requester-side and multiplier-side signals of mult_arbiter.
// slave  = the arbiter's view; master = the view of whatever drives
// requests and models the multiplier.
interface mult_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [2*DATA_W-1:0]       resp_data;
  logic                      resp_err;
  logic                      busy;
  logic [DATA_W-1:0]         mul_a;
  logic [DATA_W-1:0]         mul_b;
  logic                      mul_en;
  logic [2*DATA_W-1:0]       mul_out;
  logic                      mul_ack;

  modport slave (
    input  req, req_a, req_b, mul_out, mul_ack,
    output gnt, done, resp_data, resp_err, busy, mul_a, mul_b, mul_en
  );

  modport master (
    output req, req_a, req_b, mul_out, mul_ack,
    input  gnt, done, resp_data, resp_err, busy, mul_a, mul_b, mul_en
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one en/ack multiplier among
// NUM_REQ requesters. Optional WAIT timeout enabled by MULT_ARB_TIMEOUT_EN.
module mult_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  mult_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [2*DATA_W-1:0] resp_data_q, resp_data_d;
  logic [DATA_W-1:0]   mul_a_q, mul_a_d;
  logic [DATA_W-1:0]   mul_b_q, mul_b_d;
  logic                mul_en_q, mul_en_d;
  logic                busy_q, busy_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand_idx;
  int unsigned         cand;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                resp_err_q, resp_err_d;
`endif

  // Round-robin search: first requesting index at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state and registered-output values for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = '0;
    done_d      = '0;
    mul_en_d    = 1'b0;
    resp_data_d = resp_data_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    resp_err_d  = resp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          owner_d          = win_idx;
          mul_a_d          = bus.req_a[DATA_W*int'(win_idx) +: DATA_W];
          mul_b_d          = bus.req_b[DATA_W*int'(win_idx) +: DATA_W];
          gnt_d[win_idx]   = 1'b1;
          mul_en_d         = 1'b1;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        // A real ack takes precedence over a timeout firing on the same edge.
        if (bus.mul_ack) begin
          resp_data_d     = bus.mul_out;
          done_d[owner_q] = 1'b1;
          state_d         = RESP;
`ifdef MULT_ARB_TIMEOUT_EN
          resp_err_d      = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          resp_data_d     = '0;
          done_d[owner_q] = 1'b1;
          resp_err_d      = 1'b1;
          state_d         = RESP;
        end else begin
          cnt_d           = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      resp_data_q <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_en_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      resp_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      resp_data_q <= resp_data_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_en_q    <= mul_en_d;
      busy_q      <= busy_d;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      resp_err_q  <= resp_err_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.resp_data = resp_data_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.mul_en    = mul_en_q;
  assign bus.busy      = busy_q;
`ifdef MULT_ARB_TIMEOUT_EN
  assign bus.resp_err  = resp_err_q;
`else
  assign bus.resp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed bench for mult_arbiter; the bench plays both the
// requesters and the multiplier.
module tb_mult_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mult_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  mult_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int unsigned i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One full transaction starting from an IDLE cycle with req already set.
  task automatic txn(input int unsigned who, input logic [7:0] ea, input logic [7:0] eb,
                     input int unsigned wait_cyc, input logic [15:0] prod, input logic drop);
    logic [31:0] onehot;
    onehot = 32'd1 << who;
    tick();
    chk("gnt", bus.gnt, onehot);
    chk("mul_en_hi", bus.mul_en, 1);
    chk("mul_a", bus.mul_a, ea);
    chk("mul_b", bus.mul_b, eb);
    chk("busy_hi", bus.busy, 1);
    if (drop) bus.req[who] = 1'b0;
    tick();
    chk("gnt_clr", bus.gnt, 0);
    chk("mul_en_lo", bus.mul_en, 0);
    repeat (wait_cyc) begin
      tick();
      chk("done_wait", bus.done, 0);
    end
    bus.mul_ack = 1'b1;
    bus.mul_out = prod;
    tick();
    chk("done", bus.done, onehot);
    chk("resp_data", bus.resp_data, prod);
    chk("resp_err", bus.resp_err, 0);
    chk("busy_resp", bus.busy, 1);
    bus.mul_ack = 1'b0;
    bus.mul_out = 16'hBEEF;
    tick();
    chk("done_clr", bus.done, 0);
    chk("busy_lo", bus.busy, 0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    bus.req     = '0;
    bus.req_a   = '0;
    bus.req_b   = '0;
    bus.mul_out = '0;
    bus.mul_ack = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_data", bus.resp_data, 0);
    chk("rst_err", bus.resp_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_en", bus.mul_en, 0);
    chk("rst_a", bus.mul_a, 0);
    reset = 1'b0;
    tick();

    // Single request, ack 3 cycles after en
    set_op(0, 8'd5, 8'd6);
    bus.req = 4'b0001;
    txn(0, 8'd5, 8'd6, 2, 16'd30, 1'b1);

    // Contention from reset: 1 then 2
    do_reset();
    set_op(1, 8'd20, 8'd7);
    set_op(2, 8'd10, 8'd4);
    bus.req = 4'b0110;
    txn(1, 8'd20, 8'd7, 0, 16'd140, 1'b1);
    txn(2, 8'd10, 8'd4, 0, 16'd40, 1'b1);

    // Fairness: all four held, pointer back at 0 after reset
    do_reset();
    for (int unsigned i = 0; i < NR; i++) set_op(i, 8'(i + 1), 8'(i + 2));
    bus.req = 4'b1111;
    for (int unsigned t = 0; t < 8; t++) begin
      int unsigned w;
      w = t % 4;
      txn(w, 8'(w + 1), 8'(w + 2), t % 3, 16'((w + 1) * (w + 2)), 1'b0);
    end
    bus.req = '0;

    // Stray ack in ISSUE is ignored
    set_op(0, 8'd9, 8'd9);
    bus.req = 4'b0001;
    tick();
    chk("stray_gnt", bus.gnt, 1);
    bus.req     = '0;
    bus.mul_ack = 1'b1;
    bus.mul_out = 16'h1111;
    tick();
    chk("stray_done0", bus.done, 0);
    bus.mul_ack = 1'b0;
    tick();
    chk("stray_done1", bus.done, 0);
    bus.mul_ack = 1'b1;
    bus.mul_out = 16'd81;
    tick();
    chk("stray_done", bus.done, 1);
    chk("stray_data", bus.resp_data, 81);
    bus.mul_ack = 1'b0;
    tick();
    chk("stray_done_clr", bus.done, 0);
    tick();
    chk("stray_no_2nd", bus.done, 0);

    // Reset in WAIT
    set_op(1, 8'd3, 8'd4);
    bus.req = 4'b0010;
    tick();
    chk("mid_gnt", bus.gnt, 4'b0010);
    bus.req = '0;
    tick();
    tick();
    chk("mid_busy_pre", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_en", bus.mul_en, 0);
    chk("mid_gnt0", bus.gnt, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_data", bus.resp_data, 0);
    chk("mid_a", bus.mul_a, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_post_done", bus.done, 0);
    set_op(3, 8'd12, 8'd12);
    bus.req = 4'b1000;
    txn(3, 8'd12, 8'd12, 1, 16'd144, 1'b1);

    // Timeout behaviour
    set_op(0, 8'd7, 8'd7);
    bus.req = 4'b0001;
    tick();
    chk("to_gnt", bus.gnt, 1);
    bus.req     = '0;
    bus.mul_out = 16'h5A5A;
    tick();
`ifdef MULT_ARB_TIMEOUT_EN
    for (int unsigned c = 0; c < 15; c++) begin
      tick();
      chk("to_wait_done", bus.done, 0);
    end
    tick();
    chk("to_done", bus.done, 1);
    chk("to_err", bus.resp_err, 1);
    chk("to_data", bus.resp_data, 0);
    tick();
    chk("to_done_clr", bus.done, 0);
    chk("to_busy_lo", bus.busy, 0);
`else
    for (int unsigned c = 0; c < 100; c++) begin
      tick();
      chk("hold_busy", bus.busy, 1);
      chk("hold_done", bus.done, 0);
    end
    do_reset();
    #1;
    chk("hold_rst_busy", bus.busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
